// File: rtl/dump_tx.sv
// Capture-RAM dump transmitter: requests a dump, serializes each presented
// byte as a UART 8N1 frame, and acknowledges it back to the capture unit.
module dump_tx #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dump_req,
  output logic       busy,
  output logic       start_dump,
  input  logic       send_dump,
  input  logic [7:0] ram_data,
  output logic       dump_sent,
  input  logic       dump_finished,
  output logic       done,
  output logic [9:0] byte_cnt,
  output logic       tx
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CNT_MAX  = 512;
  localparam int unsigned STOP_IDX = 9;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    ACK,
    DRAIN
  } state_t;

  state_t state, state_next;

  logic             sh_active;
  logic [CNT_W-1:0] baud_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [7:0]       sh_data;

  logic bit_end_c;
  logic frame_end_c;
  logic sh_ready_c;
  logic load_c;

  // Shifter counts as ready during the last stop-bit cycle so frames chain with no gap.
  assign bit_end_c   = sh_active && (baud_cnt == BAUD_LAST);
  assign frame_end_c = bit_end_c && (bit_idx == IDX_W'(STOP_IDX));
  assign sh_ready_c  = !sh_active || frame_end_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    case (state)
      IDLE:      if (dump_req) state_next = REQ;
      REQ:       state_next = WAIT_DATA;
      WAIT_DATA: begin
        if (send_dump && sh_ready_c) begin
          load_c     = 1'b1;
          state_next = ACK;
        end
      end
      ACK:       state_next = dump_finished ? DRAIN : WAIT_DATA;
      DRAIN:     if (sh_ready_c) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      start_dump <= 1'b0;
      dump_sent  <= 1'b0;
      done       <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      busy       <= (state_next != IDLE);
      start_dump <= (state_next == REQ);
      dump_sent  <= (state_next == ACK);
      done       <= (state == DRAIN) && (state_next == IDLE);
      if ((state == IDLE) && dump_req) begin
        byte_cnt <= '0;
      end else if (load_c && (byte_cnt != 10'(CNT_MAX))) begin
        byte_cnt <= byte_cnt + 10'd1;
      end
    end
  end

  // UART shifter: bit_idx 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_active <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      sh_data   <= '0;
      tx        <= 1'b1;
    end else if (load_c) begin
      sh_active <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      sh_data   <= ram_data;
      tx        <= 1'b0;
    end else if (bit_end_c) begin
      baud_cnt <= '0;
      if (bit_idx == IDX_W'(STOP_IDX)) begin
        sh_active <= 1'b0;
        tx        <= 1'b1;
      end else begin
        bit_idx <= bit_idx + IDX_W'(1);
        tx      <= sh_data[0];
        sh_data <= {1'b1, sh_data[7:1]};
      end
    end else if (sh_active) begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dump_tx.sv
// Randomized bench for dump_tx: a time-based reference model predicts every
// output each cycle, and a UART decoder checks the serialized bytes.
module tb_dump_tx;

  localparam int B = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dump_req = 1'b0;
  logic       send_dump = 1'b0;
  logic [7:0] ram_data = 8'h00;
  logic       dump_finished = 1'b0;
  logic       busy, start_dump, dump_sent, done, tx;
  logic [9:0] byte_cnt;

  dump_tx #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .busy(busy),
    .start_dump(start_dump), .send_dump(send_dump), .ram_data(ram_data),
    .dump_sent(dump_sent), .dump_finished(dump_finished), .done(done),
    .byte_cnt(byte_cnt), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, expressed as event times rather than FSM states
  int         cyc = 0;
  bit         m_busy = 0;
  bit         m_drain = 0;
  int         last_acc = -1000;
  int         ack_cyc = -1000;
  int         wait_from = 0;
  int         m_cnt = 0;
  logic [7:0] m_byte = 8'h00;
  logic       e_busy = 0, e_start = 0, e_sent = 0, e_done = 0, e_tx = 1;
  int         e_cnt = 0;

  logic [7:0] exp_bytes[$];
  int         n_decoded = 0;
  int         ob_start = 0, ob_sent = 0, ob_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Model: at edge k, use cycle-k inputs to predict outputs of cycle k+1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_busy = 0; m_drain = 0; last_acc = -1000; ack_cyc = -1000;
      wait_from = 0; m_cnt = 0; m_byte = 8'h00;
      e_busy = 0; e_start = 0; e_sent = 0; e_done = 0; e_cnt = 0; e_tx = 1;
    end else begin
      int k, c, d, j;
      bit n_start, n_sent, n_done;
      k = cyc; n_start = 0; n_sent = 0; n_done = 0;
      if (m_busy && k == ack_cyc && dump_finished) m_drain = 1;
      if (m_drain && k >= last_acc + 10 * B) begin
        n_done = 1; m_busy = 0; m_drain = 0;
      end else if (m_busy && !m_drain && k >= wait_from && send_dump
                   && k >= last_acc + 10 * B) begin
        last_acc = k; m_byte = ram_data;
        m_cnt = (m_cnt < 512) ? m_cnt + 1 : 512;
        n_sent = 1; ack_cyc = k + 1; wait_from = k + 2;
      end else if (!m_busy && dump_req) begin
        m_busy = 1; n_start = 1; m_cnt = 0; wait_from = k + 2;
      end
      cyc = k + 1;
      c = k + 1;
      d = c - last_acc - 1;
      if (d >= 0 && d < 10 * B) begin
        j = d / B;
        if (j == 0) e_tx = 1'b0;
        else if (j == 9) e_tx = 1'b1;
        else e_tx = m_byte[j-1];
      end else begin
        e_tx = 1'b1;
      end
      e_start = n_start; e_sent = n_sent; e_done = n_done;
      e_busy = m_busy; e_cnt = m_cnt;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, e_busy);
    chk("start_dump", start_dump, e_start);
    chk("dump_sent", dump_sent, e_sent);
    chk("done", done, e_done);
    chk("byte_cnt", byte_cnt, e_cnt);
    chk("tx", tx, e_tx);
  end

  // Independent UART receiver sampling mid-bit
  bit         rx_active = 0;
  int         rx_t = 0;
  logic [7:0] rx_byte = 8'h00;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin rx_active = 1; rx_t = 0; end
    end else begin
      rx_t++;
      for (int j = 0; j < 8; j++) if (rx_t == B * (j + 1) + B / 2) rx_byte[j] = tx;
      if (rx_t == 9 * B + B / 2) begin
        rx_active = 0;
        chk("stop_bit", tx, 1);
        if (exp_bytes.size() == 0) chk("unexpected_frame", rx_byte, 32'hFFFF_FFFF);
        else chk("rx_byte", rx_byte, exp_bytes.pop_front());
        n_decoded++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (start_dump) ob_start++;
      if (dump_sent) ob_sent++;
      if (done) ob_done++;
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    dump_finished = 0;
    dump_req = 0;
  endtask

  task automatic pulse_req();
    @(negedge clk);
    dump_req = 1;
    dump_finished = 0;
    @(negedge clk);
    dump_req = 0;
  endtask

  // Capture-unit behaviour for one byte; returns the accept cycle
  task automatic send_byte(input logic [7:0] d, input bit last, input int gap,
                           input bit noise, output int acc);
    bit got = 0;
    acc = -1;
    repeat (gap) idle_cycle();
    send_dump = 1; ram_data = d;
    exp_bytes.push_back(d);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (dump_sent) begin
        got = 1; send_dump = 0; dump_req = 0; dump_finished = last;
        ram_data = 8'($urandom);
        acc = cyc - 1;
      end else begin
        dump_finished = noise && ($urandom_range(0, 3) == 0);
        dump_req = noise && ($urandom_range(0, 7) == 0);
      end
    end
    if (!got) begin
      chk("sent_timeout", 0, 1);
      send_dump = 0; dump_req = 0; dump_finished = 0;
    end
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      idle_cycle();
      if (done) got = 1;
    end
    chk("done_timeout", got, 1);
  endtask

  initial begin
    int acc0, acc1, acc2, s_start, s_sent, s_done, s_dec;
    logic s[40];
    logic [9:0] bits;
    bit same;

    // Reset, then a stray send_dump with no request must be ignored
    repeat (5) @(negedge clk);
    rst_n = 1;
    s_sent = ob_sent;
    send_dump = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ram_data = 8'($urandom);
    end
    send_dump = 0;
    chk("no_req_tx_idle", tx, 1);
    chk("no_req_sent", ob_sent - s_sent, 0);
    idle_cycle();

    // Single byte 0xA5 with a spurious second request while busy
    s_start = ob_start; s_sent = ob_sent; s_done = ob_done;
    pulse_req();
    idle_cycle();
    pulse_req();
    send_byte(8'hA5, 1, 1, 0, acc0);
    s[0] = tx;
    for (int i = 1; i < 40; i++) begin
      idle_cycle();
      s[i] = tx;
    end
    idle_cycle();
    chk("a5_done_time", done, 1);
    same = 1;
    for (int j = 0; j < 10; j++) begin
      bits[j] = s[4 * j];
      for (int q = 1; q < 4; q++) if (s[4 * j + q] !== s[4 * j]) same = 0;
    end
    chk("a5_bit_width", same, 1);
    chk("a5_frame", bits, 10'b11_0100_1010);
    chk("a5_byte_cnt", byte_cnt, 1);
    chk("a5_start_count", ob_start - s_start, 1);
    chk("a5_sent_count", ob_sent - s_sent, 1);
    repeat (3) idle_cycle();
    chk("a5_done_count", ob_done - s_done, 1);

    // Three back-to-back bytes
    pulse_req();
    send_byte(8'h00, 0, 1, 0, acc0);
    send_byte(8'hFF, 0, 2, 0, acc1);
    send_byte(8'h3C, 1, 2, 0, acc2);
    wait_done(100);
    chk("spacing_1", acc1 - acc0, 40);
    chk("spacing_2", acc2 - acc1, 40);
    chk("three_byte_cnt", byte_cnt, 3);
    repeat (2) idle_cycle();

    // Random short dumps with noise on dump_req / dump_finished
    for (int dn = 0; dn < 6; dn++) begin
      int len;
      len = $urandom_range(1, 6);
      pulse_req();
      for (int i = 0; i < len; i++)
        send_byte(8'($urandom), i == len - 1, $urandom_range(1, 5), 1, acc0);
      wait_done(100);
      chk("rand_byte_cnt", byte_cnt, len);
      repeat ($urandom_range(1, 4)) idle_cycle();
    end

    // Full 512-byte incrementing dump
    s_done = ob_done; s_dec = n_decoded;
    pulse_req();
    for (int i = 0; i < 512; i++)
      send_byte(8'(i), i == 511, $urandom_range(1, 3), 1, acc0);
    wait_done(100);
    chk("full_byte_cnt", byte_cnt, 512);
    repeat (3) idle_cycle();
    chk("full_busy_low", busy, 0);
    chk("full_done_count", ob_done - s_done, 1);
    chk("full_decoded", n_decoded - s_dec, 512);

    // Reset in the middle of the second byte's data bits
    pulse_req();
    send_byte(8'h11, 0, 1, 0, acc0);
    send_byte(8'h5A, 0, 1, 0, acc1);
    repeat (6) idle_cycle();
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_busy", busy, 0);
    send_dump = 0; dump_finished = 0; dump_req = 0;
    repeat (3) @(negedge clk);
    exp_bytes.delete();
    rst_n = 1;
    repeat (4) idle_cycle();
    chk("post_reset_idle", busy, 0);
    s_dec = n_decoded;
    pulse_req();
    send_byte(8'($urandom), 0, 1, 0, acc0);
    send_byte(8'($urandom), 1, 2, 0, acc1);
    wait_done(100);
    chk("post_reset_cnt", byte_cnt, 2);
    repeat (3) idle_cycle();
    chk("post_reset_decoded", n_decoded - s_dec, 2);
    chk("leftover_bytes", exp_bytes.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dump_tx.md
# dump_tx

Transmit side of the capture-RAM dump handshake. On a dump request from the command handler, it pulses `start_dump` to the capture unit. It then takes each byte the capture unit presents (`send_dump` + `ram_data`), serializes it on a UART TX line (8N1), and acknowledges with `dump_sent`. A single-byte pipeline lets the capture unit fetch the next RAM word while the current byte is still shifting out.

## Interface
- BAUD_DIV, default 868: clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- dump_req  in  1  one-cycle request from command handler to start a dump.
- busy  out  1  high from the cycle after an accepted `dump_req` until `done`.
- start_dump  out  1  one-cycle pulse to the capture unit.
- send_dump  in  1  capture unit level: `ram_data` valid, held until `dump_sent`.
- ram_data  in  8  sample byte from capture RAM.
- dump_sent  out  1  one-cycle acknowledge: byte taken.
- dump_finished  in  1  capture unit pulse, coincident with the `dump_sent` of the final byte.
- done  out  1  one-cycle pulse after the final byte's stop bit completes.
- byte_cnt  out  10  bytes accepted in the current dump (0..512).
- tx  out  1  UART serial output, idle high.

## Operation
- Control FSM states: IDLE, REQ, WAIT_DATA, ACK, DRAIN.
  - IDLE: `busy`=0. `dump_req` -> REQ; `byte_cnt` cleared to 0.
  - REQ: `start_dump`=1 for exactly this cycle -> WAIT_DATA.
  - WAIT_DATA: if `send_dump`=1 and shifter idle, load shifter with `ram_data`, `byte_cnt`+1 -> ACK. Otherwise stay.
  - ACK: `dump_sent`=1 for exactly this cycle. If `dump_finished`=1 this cycle -> DRAIN, else -> WAIT_DATA.
  - DRAIN: wait for shifter idle, then pulse `done` -> IDLE.
- The UART shifter is independent of the FSM.
  - Frame: start bit 0, data bits LSB first, stop bit 1. Each bit lasts BAUD_DIV cycles; frame = 10*BAUD_DIV cycles.
  - Baud counter is 16 bits, bit index is 4 bits. Shifter is idle when no frame is in progress.
  - A load while idle begins the start bit on the next cycle.
- `dump_req` is ignored in any state other than IDLE.
- `dump_finished` is ignored outside ACK.
- `send_dump` is sampled only in WAIT_DATA. The capture unit drops it during the `dump_sent` cycle, so no double-accept occurs.
- `byte_cnt` saturates at 512. It holds its value after `done` until the next accepted `dump_req`.

## Timing
- Reset values: `busy`=0, `start_dump`=0, `dump_sent`=0, `done`=0, `byte_cnt`=0, `tx`=1. FSM resets to IDLE; shifter resets to idle.
- `dump_req` at cycle t -> `start_dump` at t+1, `busy`=1 from t+1.
- `send_dump` accepted at cycle n:
  - `dump_sent` at n+1.
  - `tx` falls at n+1.
  - Stop bit ends at n+1+10*BAUD_DIV.
- Next byte: it may be presented any time after `dump_sent`, but it is accepted only when the shifter is idle. Back-to-back frames therefore have zero idle bit time, provided `send_dump` is already waiting.
- `done` is asserted the cycle after the shifter returns idle in DRAIN. `busy` falls in the same cycle as `done`.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous), and the FSM returns to IDLE. No partial-frame recovery.
- `dump_req` coincident with `done`: ignored, because the FSM is still in DRAIN.

## Test plan
- Reset with BAUD_DIV=4: all outputs at their reset values. Holding `send_dump`=1 with no request -> `tx` stays 1 and `dump_sent` stays 0 for 100 cycles.
- `dump_req` pulse -> `start_dump` exactly 1 cycle later and only once. A second `dump_req` while busy -> no further `start_dump`.
- Single byte 0xA5 with `dump_finished` in ACK:
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - `dump_sent` occurs once.
  - `done` occurs 1 cycle after the stop bit; `byte_cnt`=1.
- Three bytes 0x00, 0xFF, 0x3C with `send_dump` re-asserted 2 cycles after each `dump_sent`:
  - Frames are contiguous (no idle high between stop and next start).
  - Accept times are spaced 40 cycles apart; `byte_cnt`=3.
- Capture-unit model, 512-byte dump of an incrementing pattern:
  - 512 frames decode to the matching pattern; `done`=1 once.
  - `byte_cnt`=512; `busy` is low afterwards.
- Assert `rst_n`=0 mid-data-bit of the second byte:
  - `tx`=1 the same cycle.
  - After release, FSM is IDLE and a fresh `dump_req` completes a correct dump.
